// File: rtl/wb_regfile_pkg.sv
// rtl/wb_regfile_pkg.sv - shared widths and writeback-select encoding
package wb_regfile_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 1 << ADDR_W;
    localparam int REG_ZERO = 0;

    typedef enum logic {
        WB_SEL_ALU = 1'b0,
        WB_SEL_MEM = 1'b1
    } wb_sel_e;

    function automatic logic isZeroReg(input logic [ADDR_W-1:0] addr);
        return addr == ADDR_W'(REG_ZERO);
    endfunction

endpackage

// File: rtl/wb_regfile_gpr_array.sv
// rtl/wb_regfile_gpr_array.sv - register storage, one sync write port, two async read ports
module gpr_array #(
    parameter int DATA_W = wb_regfile_pkg::DATA_W,
    parameter int ADDR_W = wb_regfile_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] wAddr,
    input  logic [DATA_W-1:0] wData,
    input  logic [ADDR_W-1:0] rAddrA,
    input  logic [ADDR_W-1:0] rAddrB,
    output logic [DATA_W-1:0] rDataA,
    output logic [DATA_W-1:0] rDataB
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (wAddr != '0)) begin
            mem[wAddr] <= wData;
        end
    end

    // Entry 0 is never written, but the read side forces zero as well so the rule holds by construction.
    assign rDataA = (rAddrA == '0) ? '0 : mem[rAddrA];
    assign rDataB = (rAddrB == '0) ? '0 : mem[rAddrB];

endmodule

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - writeback mux, commit control, bypass and commit counter around gpr_array
module wb_regfile #(
    parameter int DATA_W = wb_regfile_pkg::DATA_W,
    parameter int ADDR_W = wb_regfile_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              RegWrite_in,
    input  logic              Mem2Reg_in,
    input  logic [ADDR_W-1:0] RdAddr_in,
    input  logic [DATA_W-1:0] MemAddr_in,
    input  logic [DATA_W-1:0] MemReadData_in,
    input  logic [ADDR_W-1:0] RsAddr_in,
    input  logic [ADDR_W-1:0] RtAddr_in,
    output logic [DATA_W-1:0] RsData_out,
    output logic [DATA_W-1:0] RtData_out,
    output logic [DATA_W-1:0] WbData_out,
    output logic              WbValid_out,
    output logic [31:0]       WbCount_out
);
    import wb_regfile_pkg::*;

    logic              we;
    logic [DATA_W-1:0] arrRs;
    logic [DATA_W-1:0] arrRt;
    logic [31:0]       wbCount;

    assign WbData_out = (wb_sel_e'(Mem2Reg_in) == WB_SEL_MEM) ? MemReadData_in : MemAddr_in;

    // rst_n gates the commit so a held reset also disables the bypass path.
    assign we          = rst_n && RegWrite_in && (RdAddr_in != ADDR_W'(REG_ZERO));
    assign WbValid_out = we;

    gpr_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_gpr (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (we),
        .wAddr  (RdAddr_in),
        .wData  (WbData_out),
        .rAddrA (RsAddr_in),
        .rAddrB (RtAddr_in),
        .rDataA (arrRs),
        .rDataB (arrRt)
    );

    assign RsData_out = (we && (RsAddr_in == RdAddr_in)) ? WbData_out : arrRs;
    assign RtData_out = (we && (RtAddr_in == RdAddr_in)) ? WbData_out : arrRt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbCount <= '0;
        end else if (we) begin
            wbCount <= wbCount + 32'd1;
        end
    end

    assign WbCount_out = wbCount;

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Writeback stage and general-purpose register file for the five-stage pipeline: the consumer at the far end of the MEM/WB pipeline register. Each cycle it takes the MEM/WB outputs, selects the writeback value (load data or ALU/address result), and commits it to a 32 x 32-bit register array. It serves the two ID-stage read ports with same-cycle write-to-read bypass, so a value written in WB is visible to the instruction decoding in that same cycle. It also exports the writeback value and a committed-write counter for forwarding and debug.

## Interface
Parameters:
- DATA_W, 32, register and datapath width
- ADDR_W, 5, register address width; the array holds 2^ADDR_W entries

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- RegWrite_in  input  1  WB control: commit this cycle's result
- Mem2Reg_in  input  1  WB control: 1 selects MemReadData_in, 0 selects MemAddr_in
- RdAddr_in  input  ADDR_W  destination register
- MemAddr_in  input  DATA_W  ALU result / memory address from MEM/WB
- MemReadData_in  input  DATA_W  load data from MEM/WB
- RsAddr_in  input  ADDR_W  ID read port A address
- RtAddr_in  input  ADDR_W  ID read port B address
- RsData_out  output  DATA_W  read port A data (combinational)
- RtData_out  output  DATA_W  read port B data (combinational)
- WbData_out  output  DATA_W  selected writeback value (combinational, for the forwarding unit)
- WbValid_out  output  1  high when a commit takes effect this cycle
- WbCount_out  output  32  number of committed writes since reset (registered)

## Operation
- WbData_out = Mem2Reg_in ? MemReadData_in : MemAddr_in. No width change; no sign handling (done upstream).
- Commit condition: we = rst_n && RegWrite_in && (RdAddr_in != 0). WbValid_out = we.
- On rising clk with we: gpr[RdAddr_in] <= WbData_out; WbCount_out <= WbCount_out + 1 (wraps 0xFFFF_FFFF -> 0).
- Register 0 is hardwired zero. Writes to it are dropped, are not counted, and do not bypass. Reads of it return 0.
- Read port X (Rs or Rt): if we && RsAddr/RtAddr == RdAddr_in, return WbData_out (bypass). Otherwise return gpr[addr].
- Both ports may read the same address, and both may hit the bypass, in the same cycle.
- RegWrite_in = 0 makes Mem2Reg_in, RdAddr_in and the data inputs don't-care for state. WbData_out still reflects the mux.

## Timing
- Reset (rst_n low, asynchronous): all gpr entries become 0 and WbCount_out becomes 0. WbValid_out = 0; bypass is disabled.
  - While reset is held, RsData_out and RtData_out read 0.
  - WbData_out remains the combinational mux value.
- Reset asserted mid-cycle, with a commit pending: the write is lost and the array is cleared immediately.
- Reset release: the first commit can occur on the first rising edge with rst_n high.
- Write latency: 1 edge to the array. Read-after-write latency is 0 cycles via the bypass. From the next cycle on, the array supplies the value.
- Read ports have no clock and no enable; outputs settle within the same cycle as an address change.
- Back-to-back writes to the same register: the last edge wins. The bypass always reflects the current cycle's writer.
- There is no stall input. The block commits whatever MEM/WB presents; bubbles arrive as RegWrite_in = 0.

## Structure
- Shared package: DATA_W, ADDR_W, REG_ZERO (= 0) and the writeback-select encoding (WB_SEL_ALU = 0, WB_SEL_MEM = 1), all reused by the control unit and the forwarding unit.
- One sub-module, gpr_array, contains:
  - the 2^ADDR_W x DATA_W storage with asynchronous clear;
  - one synchronous write port and two asynchronous read ports;
  - the zero-register rule.
- The writeback mux, bypass compare, commit counter and WbValid_out live in wb_regfile.

## Test plan
- Reset and zero register:
  - Assert rst_n=0 after writes are loaded, then read every register -> all 0 and WbCount_out=0.
  - Commit RegWrite=1, Rd=0, data 0xDEADBEEF -> Rs=0 reads 0, WbValid_out=0, WbCount_out unchanged.
- Mux select and counting:
  - Rd=8, Mem2Reg=0, MemAddr=0x0000_1234, MemReadData=0xFFFF_0000 -> next cycle r8 reads 0x0000_1234.
  - Same with Mem2Reg=1 -> r8 reads 0xFFFF_0000.
  - WbCount_out increments by 1 per commit.
- Same-cycle bypass:
  - Commit Rd=9 = 0x0BAD_F00D with Rs=9 and Rt=9 in the same cycle -> both outputs are 0x0BAD_F00D before the edge.
  - With RegWrite=0 in that cycle -> both show the old r9 value.
- Back-to-back and independent ports:
  - Write r5=1, then r5=2 on consecutive edges, Rs=5, Rt=6 -> Rs tracks 1 then 2, Rt unchanged.
- Reset mid-operation:
  - rst_n falls between edges while a commit of r3=0x55 is pending -> r3 reads 0 after release, count=0.
- Counter wrap:
  - Force the counter to 0xFFFF_FFFF and commit once -> WbCount_out=0.
